// File: rtl/moore.sv
// Moore FSM detecting the serial pattern 1011 (MSB first) with overlap,
// plus a saturating count of completed detections.
module moore (
   input  logic       din,
   input  logic       clk,
   input  logic       rst,
   output logic       y,
   output logic [7:0] det_count,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S0 = 3'd0,
      S1 = 3'd1,
      S2 = 3'd2,
      S3 = 3'd3,
      S4 = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   // State register and detection counter; the counter follows next_state so
   // it lands on the same edge the FSM enters S4.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S0;
         det_count <= 8'd0;
      end else begin
         state <= next_state;
         if (next_state == S4 && det_count != 8'd255) begin
            det_count <= det_count + 8'd1;
         end
      end
   end

   // Each state remembers the longest matched prefix; illegal codes recover to S0.
   always_comb begin
      next_state = S0;
      case (state)
         S0:      next_state = din ? S1 : S0;
         S1:      next_state = din ? S1 : S2;
         S2:      next_state = din ? S3 : S0;
         S3:      next_state = din ? S4 : S2;
         S4:      next_state = din ? S1 : S2;
         default: next_state = S0;
      endcase
   end

   always_comb begin
      y       = 1'b0;
      state_o = state;
      if (state == S4) begin
         y = 1'b1;
      end
   end

endmodule

// File: tb/tb_moore.sv
// Self-checking bench for the 1011 Moore detector: vector table, directed
// multi-cycle sequences and a randomized run against a suffix-matching model.
module tb_moore;

   logic       clk = 1'b0;
   logic       rst;
   logic       din;
   logic       y;
   logic [7:0] det_count;
   logic [2:0] state_o;

   int checks   = 0;
   int failures = 0;

   moore dut (
      .din       (din),
      .clk       (clk),
      .rst       (rst),
      .y         (y),
      .det_count (det_count),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       din;
      logic       y;
      logic [2:0] state;
      logic [7:0] count;
   } vec_t;

   vec_t vecs[$];

   // Reference model: bits seen since reset and number of completed matches.
   logic [3:0] mLast;
   int         mLen;
   int         mMatches;

   function automatic void addVec(input logic r, input logic d, input logic ey,
                                  input logic [2:0] es, input logic [7:0] ec);
      vec_t v;
      v.rst   = r;
      v.din   = d;
      v.y     = ey;
      v.state = es;
      v.count = ec;
      vecs.push_back(v);
   endfunction

   // Length of the longest suffix of the received bits that is a prefix of 1011.
   function automatic int modelState();
      int lastInt;
      int mask;
      int pat;
      lastInt = int'(mLast);
      for (int k = 4; k >= 1; k--) begin
         mask = (1 << k) - 1;
         pat  = 11 >> (4 - k);
         if (mLen >= k && (lastInt & mask) == pat) return k;
      end
      return 0;
   endfunction

   function automatic void modelStep(input logic r, input logic d);
      if (!r) begin
         mLen  = 0;
         mLast = 4'd0;
         mMatches = 0;
      end else begin
         mLast = {mLast[2:0], d};
         if (mLen < 4) mLen++;
         if (modelState() == 4 && mMatches < 255) mMatches++;
      end
   endfunction

   task automatic applyStimulus(input logic r, input logic d);
      rst = r;
      din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      logic seq24[14];
      int   yIdx;
      int   m;
      logic r;
      logic d;

      rst = 1'b0;
      din = 1'b0;
      applyStimulus(1'b0, 1'b1);

      // Table: reset, 1011, reset from S4, 1001011, reset, 1111, reset, 0000.
      addVec(0, 1, 0, 3'd0, 8'd0);
      addVec(1, 1, 0, 3'd1, 8'd0);
      addVec(1, 0, 0, 3'd2, 8'd0);
      addVec(1, 1, 0, 3'd3, 8'd0);
      addVec(1, 1, 1, 3'd4, 8'd1);
      addVec(0, 1, 0, 3'd0, 8'd0);
      addVec(1, 1, 0, 3'd1, 8'd0);
      addVec(1, 0, 0, 3'd2, 8'd0);
      addVec(1, 0, 0, 3'd0, 8'd0);
      addVec(1, 1, 0, 3'd1, 8'd0);
      addVec(1, 0, 0, 3'd2, 8'd0);
      addVec(1, 1, 0, 3'd3, 8'd0);
      addVec(1, 1, 1, 3'd4, 8'd1);
      addVec(0, 0, 0, 3'd0, 8'd0);
      addVec(1, 1, 0, 3'd1, 8'd0);
      addVec(1, 1, 0, 3'd1, 8'd0);
      addVec(1, 1, 0, 3'd1, 8'd0);
      addVec(1, 1, 0, 3'd1, 8'd0);
      addVec(0, 1, 0, 3'd0, 8'd0);
      addVec(1, 0, 0, 3'd0, 8'd0);
      addVec(1, 0, 0, 3'd0, 8'd0);
      addVec(1, 0, 0, 3'd0, 8'd0);
      addVec(1, 0, 0, 3'd0, 8'd0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].din);
         checkOutput($sformatf("vec%0d_y", i), {7'd0, y}, {7'd0, vecs[i].y});
         checkOutput($sformatf("vec%0d_state", i), {5'd0, state_o}, {5'd0, vecs[i].state});
         checkOutput($sformatf("vec%0d_count", i), det_count, vecs[i].count);
      end

      // Overlapping stream: pulses after bits 5, 8 and 13.
      seq24 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      applyStimulus(1'b0, 1'b0);
      for (int i = 0; i < 14; i++) begin
         applyStimulus(1'b1, seq24[i]);
         yIdx = (i == 4 || i == 7 || i == 12) ? 1 : 0;
         checkOutput($sformatf("ovl_bit%0d_y", i + 1), {7'd0, y}, yIdx[7:0]);
      end
      checkOutput("ovl_count", det_count, 8'd3);

      // Reset in the middle of 101 must discard history.
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("midrst_pre_state", {5'd0, state_o}, 8'd3);
      applyStimulus(1'b0, 1'b1);
      checkOutput("midrst_rst_state", {5'd0, state_o}, 8'd0);
      applyStimulus(1'b1, 1'b1);
      checkOutput("midrst_y", {7'd0, y}, 8'd0);
      checkOutput("midrst_state", {5'd0, state_o}, 8'd1);
      checkOutput("midrst_count", det_count, 8'd0);

      // 260 back-to-back matches: 1011 then 259 x 011; counter saturates.
      applyStimulus(1'b0, 1'b0);
      m = 0;
      for (int g = 0; g < 260; g++) begin
         if (g == 0) applyStimulus(1'b1, 1'b1);
         applyStimulus(1'b1, 1'b0);
         checkOutput($sformatf("sat_g%0d_y0", g), {7'd0, y}, 8'd0);
         applyStimulus(1'b1, 1'b1);
         checkOutput($sformatf("sat_g%0d_y1", g), {7'd0, y}, 8'd0);
         applyStimulus(1'b1, 1'b1);
         m++;
         checkOutput($sformatf("sat_g%0d_y2", g), {7'd0, y}, 8'd1);
         checkOutput($sformatf("sat_g%0d_count", g), det_count, (m > 255) ? 8'd255 : m[7:0]);
      end

      // Randomized run against the reference model.
      applyStimulus(1'b0, 1'b1);
      modelStep(1'b0, 1'b1);
      for (int i = 0; i < 1500; i++) begin
         r = ($urandom_range(15) != 0);
         d = 1'($urandom_range(1));
         applyStimulus(r, d);
         modelStep(r, d);
         checkOutput($sformatf("rnd%0d_y", i), {7'd0, y}, (modelState() == 4) ? 8'd1 : 8'd0);
         checkOutput($sformatf("rnd%0d_state", i), {5'd0, state_o}, 8'(modelState()));
         checkOutput($sformatf("rnd%0d_count", i), det_count, 8'(mMatches));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/moore.md
MOORE -- requirements
Module: moore

Interface
- REQ-001: No parameters; pattern fixed at 1011, MSB-first (first bit received is 1).
- REQ-002: Port declaration order SHALL be din, clk, rst, y, det_count, state_o, so the first four connect correctly by position.
- REQ-003: clk  input  1  sole clock; all state changes on its rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-low (0 = reset), sampled on rising clk.
- REQ-005: din  input  1  serial data bit, sampled on every rising clk edge.
- REQ-006: y  output  1  detect flag; 1 while the FSM is in the DETECT state.
- REQ-007: det_count  output  8  saturating count of completed detections.
- REQ-008: state_o  output  3  current state encoding, for debug/observability.

Function
- REQ-009: The block SHALL be a Moore FSM; y SHALL depend only on the registered state, never combinationally on din.
- REQ-010: States and state_o encodings SHALL be: S0 idle = 3'd0, S1 "1" = 3'd1, S2 "10" = 3'd2, S3 "101" = 3'd3, S4 "1011" detect = 3'd4.
- REQ-011: Transitions SHALL be as follows (din=0 / din=1):
  - S0: S0 / S1
  - S1: S2 / S1
  - S2: S0 / S3
  - S3: S2 / S4
  - S4: S2 / S1
- REQ-012: Detection SHALL be overlapping: the trailing 1 of a match counts as the leading 1 of the next match (S4 with din=1 goes to S1; S4 with din=0 goes to S2).
- REQ-013: y SHALL be 1 exactly when the state is S4 and 0 in all other states.
- REQ-014: Latency: y rises in the clock cycle after the edge that samples the fourth pattern bit, and stays high for exactly one cycle per match.
- REQ-015: Two matches SHALL be no closer than 3 cycles apart; for example, 1011011 produces y pulses 3 cycles apart.
- REQ-016: det_count SHALL increment by 1 on each edge where the next state is S4, and SHALL saturate at 8'd255 with no wrap-around.
- REQ-017: Unused encodings 3'd5 to 3'd7 SHALL return to S0 on the next edge with y=0; det_count is unchanged.
- REQ-018: A din value of X/Z is not supported; the bench SHALL drive defined values whenever rst=1.

Reset
- REQ-019: Reset SHALL be synchronous: while rst=0 at a rising edge, the next state is S0, y=0, det_count=0 and state_o=3'd0.
- REQ-020: din SHALL be ignored during reset.
- REQ-021: Reset asserted mid-sequence (in any state, including S4) SHALL discard partial-match history; a bit sequence completed across the reset SHALL NOT produce a detection.
- REQ-022: After rst returns to 1, the first sampled din bit SHALL be treated as the start of a fresh sequence from S0.

Verification
- REQ-023: Reset, then din 1,0,1,1 on successive edges -> y=1 for one cycle after the 4th edge; state_o=4; det_count=1.
- REQ-024: din 0,1,0,1,1,0,1,1,0,1,0,1,1,0 (one bit per edge after reset) -> y pulses three times, one cycle after each of bits 5, 8 and 13; det_count=3.
- REQ-025: din 1,0,0,1,0,1,1 -> states S1,S2,S0,S1,S2,S3,S4; exactly one y pulse, after the last bit.
- REQ-026: din 1,0,1, then rst=0 for one edge, then din 1 -> no y pulse; state_o=1 after the final edge.
- REQ-027: din 1,1,1,1 and 0,0,0,0 -> y stays 0 throughout; states S1,S1,S1,S1 and S0,S0,S0,S0 respectively.
- REQ-028: Drive 260 back-to-back overlapping matches (1011 followed by repeated 011) -> det_count holds at 255 and y keeps pulsing every 3 cycles.
